// File: rtl/arp_rx.sv
// arp_rx: GMII receive-side ARP frame parser. Checks the preamble/SFD, the Ethernet header
//         (destination MAC, ethertype 0x0806) and the ARP payload (opcode, target IP).
//         It reports the sender MAC/IP and opcode of ARP frames addressed to this board.
// Latency: arp_rx_done pulses 1 cycle after the last target-IP byte is sampled. With
//          ARP_RX_CRC_CHK_EN defined, it instead pulses 1 cycle after gmii_rx_dv falls.
// Backpressure: none. The PHY stream cannot be stalled; one byte is consumed per cycle while dv=1.
// Ports:  gmii_rx_clk, rst      - receive clock, asynchronous active-high reset
//         gmii_rx_dv, gmii_rxd  - raw receive byte stream from the PHY
//         arp_rx_done           - one-cycle pulse per accepted frame
//         arp_rx_type           - 0 = request, 1 = reply (valid from done onward)
//         src_mac, src_ip       - sender addresses of the last accepted frame
// Option: define ARP_RX_CRC_CHK_EN to report a frame only when its Ethernet FCS is good.
module arp_rx #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd0, 8'd2}
) (
    input  logic        gmii_rx_clk,
    input  logic        rst,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        arp_rx_done,
    output logic        arp_rx_type,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip
);

    // Last byte index of each counted section.
    localparam logic [4:0] PRE_LAST = 5'd7;   // SFD position inside the preamble
    localparam logic [4:0] ETH_LAST = 5'd13;
    localparam logic [4:0] ARP_LAST = 5'd27;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_ETH_HEAD,
        S_ARP_DATA,
        S_RX_END
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    // Set once dv has been seen low. A frame that is already running when reset releases
    // must not be picked up part-way through.
    logic        arm_q;
    logic [39:0] dst_mac_q;     // first five destination bytes; the sixth is compared live
    logic [47:0] smac_sr_q;
    logic [31:0] sip_sr_q;
    logic [23:0] tip_sr_q;      // first three target-IP bytes; the fourth is compared live
    logic        type_sr_q;

    logic [47:0] dst_mac_d;
    logic [31:0] tip_d;
    logic        dst_ok;
    logic        tip_ok;

    assign dst_mac_d = {dst_mac_q, gmii_rxd};
    assign tip_d     = {tip_sr_q, gmii_rxd};
    assign dst_ok    = (dst_mac_d == BOARD_MAC) || (dst_mac_d == 48'hFFFF_FFFF_FFFF);
    assign tip_ok    = (tip_d == BOARD_IP);

`ifdef ARP_RX_CRC_CHK_EN
    // The reflected CRC-32 (0x04C11DB7 reversed = 0xEDB88320) is shifted LSB first.
    // The residue of a good frame in this bit order is 0xDEBB20E3. Bit-reversed, that is
    // the familiar 0xC704DD7B.
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] crc_rev;
    logic        crc_ok;
    logic        pass_q;        // ARP content was good at byte 27; waiting for the FCS verdict

    always_comb begin
        crc_d = crc_q;
        for (int i = 0; i < 8; i++) begin
            crc_d = {1'b0, crc_d[31:1]} ^ ((crc_d[0] ^ gmii_rxd[i]) ? 32'hEDB88320 : 32'h0);
        end
        for (int i = 0; i < 32; i++) begin
            crc_rev[i] = crc_q[31-i];
        end
    end

    assign crc_ok = (crc_rev == CRC_RESIDUE);

    // The CRC is re-seeded throughout the preamble. It then accumulates every byte from
    // the first destination-MAC byte up to the last FCS byte.
    always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
            crc_q <= '0;
        end else if (state_q == S_PREAMBLE) begin
            crc_q <= '1;
        end else if (gmii_rx_dv && (state_q == S_ETH_HEAD || state_q == S_ARP_DATA ||
                                    state_q == S_RX_END)) begin
            crc_q <= crc_d;
        end
    end
`endif

    always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            arm_q       <= 1'b0;
            dst_mac_q   <= '0;
            smac_sr_q   <= '0;
            sip_sr_q    <= '0;
            tip_sr_q    <= '0;
            type_sr_q   <= 1'b0;
            arp_rx_done <= 1'b0;
            arp_rx_type <= 1'b0;
            src_mac     <= '0;
            src_ip      <= '0;
`ifdef ARP_RX_CRC_CHK_EN
            pass_q      <= 1'b0;
`endif
        end else begin
            arp_rx_done <= 1'b0;
            if (!gmii_rx_dv) begin
                arm_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (gmii_rx_dv) begin
                        if (arm_q && gmii_rxd == 8'h55) begin
                            state_q <= S_PREAMBLE;
                            cnt_q   <= 5'd1;
                        end else begin
                            // Not a clean frame start: wait for the line to go idle.
                            state_q <= S_RX_END;
                        end
                    end
                end

                S_PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == PRE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= (gmii_rxd == 8'hD5) ? S_ETH_HEAD : S_RX_END;
`ifdef ARP_RX_CRC_CHK_EN
                        pass_q  <= 1'b0;
`endif
                    end else if (gmii_rxd == 8'h55) begin
                        cnt_q <= cnt_q + 5'd1;
                    end else begin
                        state_q <= S_RX_END;
                        cnt_q   <= '0;
                    end
                end

                S_ETH_HEAD: begin
                    if (!gmii_rx_dv) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q < 5'd5) begin
                            dst_mac_q <= {dst_mac_q[31:0], gmii_rxd};
                        end
                        // Source MAC (bytes 6-11) is ignored.
                        if ((cnt_q == 5'd5  && !dst_ok) ||
                            (cnt_q == 5'd12 && gmii_rxd != 8'h08) ||
                            (cnt_q == ETH_LAST && gmii_rxd != 8'h06)) begin
                            state_q <= S_RX_END;
                            cnt_q   <= '0;
                        end else if (cnt_q == ETH_LAST) begin
                            state_q <= S_ARP_DATA;
                            cnt_q   <= '0;
                        end
                    end
                end

                S_ARP_DATA: begin
                    if (!gmii_rx_dv) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                        // Opcode low byte is known to be 1 or 2 here, so bit 1 marks a reply.
                        if (cnt_q == 5'd7) begin
                            type_sr_q <= gmii_rxd[1];
                        end
                        if (cnt_q >= 5'd8 && cnt_q <= 5'd13) begin
                            smac_sr_q <= {smac_sr_q[39:0], gmii_rxd};
                        end
                        if (cnt_q >= 5'd14 && cnt_q <= 5'd17) begin
                            sip_sr_q <= {sip_sr_q[23:0], gmii_rxd};
                        end
                        if (cnt_q >= 5'd24 && cnt_q <= 5'd26) begin
                            tip_sr_q <= {tip_sr_q[15:0], gmii_rxd};
                        end

                        if ((cnt_q == 5'd6 && gmii_rxd != 8'h00) ||
                            (cnt_q == 5'd7 && gmii_rxd != 8'h01 && gmii_rxd != 8'h02)) begin
                            state_q <= S_RX_END;
                            cnt_q   <= '0;
                        end else if (cnt_q == ARP_LAST) begin
                            state_q <= S_RX_END;
                            cnt_q   <= '0;
`ifdef ARP_RX_CRC_CHK_EN
                            pass_q  <= tip_ok;
`else
                            if (tip_ok) begin
                                arp_rx_done <= 1'b1;
                                arp_rx_type <= type_sr_q;
                                src_mac     <= smac_sr_q;
                                src_ip      <= sip_sr_q;
                            end
`endif
                        end
                    end
                end

                S_RX_END: begin
                    // Drain padding, FCS or the rest of a rejected frame.
                    cnt_q <= '0;
                    if (!gmii_rx_dv) begin
                        state_q <= S_IDLE;
`ifdef ARP_RX_CRC_CHK_EN
                        pass_q  <= 1'b0;
                        if (pass_q && crc_ok) begin
                            arp_rx_done <= 1'b1;
                            arp_rx_type <= type_sr_q;
                            src_mac     <= smac_sr_q;
                            src_ip      <= sip_sr_q;
                        end
`endif
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arp_rx.sv
// tb_arp_rx: self-checking bench for arp_rx. It builds whole GMII frames from field values
// and decides acceptance from the frame fields alone. It then checks the done timing,
// the reported addresses and the held outputs against that decision.
module tb_arp_rx;

    localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BOARD_IP  = 32'hC0A80002;
`ifdef ARP_RX_CRC_CHK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    // Position of ARP byte 27 in the wire stream: 8 preamble + 14 header + 27.
    localparam int TGT_LAST = 49;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dv  = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic        done;
    logic        typ;
    logic [47:0] mac;
    logic [31:0] ip;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    arp_rx dut (
        .gmii_rx_clk (clk),
        .rst         (rst),
        .gmii_rx_dv  (dv),
        .gmii_rxd    (rxd),
        .arp_rx_done (done),
        .arp_rx_type (typ),
        .src_mac     (mac),
        .src_ip      (ip)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- done monitor ----------------
    int          ev_cyc[$];
    logic [47:0] ev_mac[$];
    logic [31:0] ev_ip[$];
    logic        ev_typ[$];
    logic        done_prev = 1'b0;
    logic [80:0] prev_out;
    int          width_err = 0;
    int          hold_err  = 0;

    always @(negedge clk) begin
        if (done) begin
            ev_cyc.push_back(cyc);
            ev_mac.push_back(mac);
            ev_ip.push_back(ip);
            ev_typ.push_back(typ);
        end
        if (done && done_prev) width_err++;
        if (!rst && !done && {typ, mac, ip} !== prev_out) hold_err++;
        prev_out  = {typ, mac, ip};
        done_prev = done;
    end

    // ---------------- frame fields and reference model ----------------
    logic [47:0] f_dst, f_seth, f_smac, f_tmac;
    logic [15:0] f_etype, f_op;
    logic [31:0] f_sip, f_tip;
    int          f_pad;
    logic        f_pre_bad, f_fcs_flip;
    int          f_pre_idx;
    logic [7:0]  f_pre_byte;
    logic [7:0]  tx_q[$];

    // Expected output state of the DUT.
    logic [47:0] m_mac = '0;
    logic [31:0] m_ip  = '0;
    logic        m_typ = 1'b0;

    function automatic bit model_accept();
        return !f_pre_bad && (f_dst == BOARD_MAC || f_dst == 48'hFFFF_FFFF_FFFF) &&
               f_etype == 16'h0806 && (f_op == 16'd1 || f_op == 16'd2) &&
               f_tip == BOARD_IP && (!CRC_EN || !f_fcs_flip);
    endfunction

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic set_base();
        f_dst = 48'hFFFF_FFFF_FFFF; f_seth = 48'h001122334466; f_etype = 16'h0806;
        f_op = 16'd1; f_smac = 48'h001122334466; f_sip = 32'hC0A80003;
        f_tmac = 48'h0; f_tip = BOARD_IP; f_pad = 18;
        f_pre_bad = 1'b0; f_fcs_flip = 1'b0; f_pre_idx = 1; f_pre_byte = 8'h55;
    endtask

    task automatic build_frame();
        logic [7:0]  pl[$];
        logic [31:0] c;
        pl = {};
        for (int i = 5; i >= 0; i--) pl.push_back(f_dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) pl.push_back(f_seth[i*8 +: 8]);
        pl.push_back(f_etype[15:8]); pl.push_back(f_etype[7:0]);
        pl.push_back(8'h00); pl.push_back(8'h01); pl.push_back(8'h08); pl.push_back(8'h00);
        pl.push_back(8'h06); pl.push_back(8'h04);
        pl.push_back(f_op[15:8]); pl.push_back(f_op[7:0]);
        for (int i = 5; i >= 0; i--) pl.push_back(f_smac[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) pl.push_back(f_sip[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) pl.push_back(f_tmac[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) pl.push_back(f_tip[i*8 +: 8]);
        for (int i = 0; i < f_pad; i++) pl.push_back(8'($urandom));
        c = 32'hFFFF_FFFF;
        foreach (pl[i]) c = crc_byte(c, pl[i]);
        c = ~c;
        tx_q = {};
        for (int i = 0; i < 7; i++) tx_q.push_back(8'h55);
        tx_q.push_back(8'hD5);
        foreach (pl[i]) tx_q.push_back(pl[i]);
        tx_q.push_back(c[7:0] ^ {7'd0, f_fcs_flip});
        tx_q.push_back(c[15:8]); tx_q.push_back(c[23:16]); tx_q.push_back(c[31:24]);
        if (f_pre_bad) tx_q[f_pre_idx] = f_pre_byte;
    endtask

    task automatic ev_clear();
        ev_cyc.delete(); ev_mac.delete(); ev_ip.delete(); ev_typ.delete();
    endtask

    // Drives tx_q (stopping before byte cut_at), then holds dv low for ifg cycles.
    // exp_cyc: monitor cycle stamp at which done is expected, should the frame be accepted.
    task automatic send_frame(input int cut_at, input int ifg, output int exp_cyc);
        int e_nc, e_crc;
        e_nc = -1;
        for (int i = 0; i < tx_q.size() && i != cut_at; i++) begin
            @(negedge clk); dv = 1'b1; rxd = tx_q[i];
            if (i == TGT_LAST) e_nc = cyc + 1;
        end
        @(negedge clk); dv = 1'b0; rxd = 8'h00; e_crc = cyc + 1;
        repeat (ifg - 1) @(negedge clk);
        exp_cyc = CRC_EN ? e_crc : e_nc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (typ !== 1'b0) begin n_err++; $display("FAIL rst_type: got %b want 0", typ); end
        n_cmp++; if (mac !== 48'h0) begin n_err++; $display("FAIL rst_mac: got %h want 0", mac); end
        n_cmp++; if (ip !== 32'h0) begin n_err++; $display("FAIL rst_ip: got %h want 0", ip); end
    endtask

    task automatic test_request();
        int ec;
        set_base(); build_frame(); ev_clear();
        send_frame(-1, 2, ec);
        repeat (3) @(negedge clk);
        n_cmp++; if (ev_cyc.size() != 1) begin n_err++; $display("FAIL req_count: got %0d want 1", ev_cyc.size()); end
        if (ev_cyc.size() >= 1) begin
            n_cmp++; if (ev_cyc[0] != ec) begin n_err++; $display("FAIL req_latency: got cyc %0d want %0d", ev_cyc[0], ec); end
            n_cmp++; if (ev_typ[0] !== 1'b0) begin n_err++; $display("FAIL req_type: got %b want 0", ev_typ[0]); end
        end
        n_cmp++; if (mac !== 48'h001122334466) begin n_err++; $display("FAIL req_mac: got %h want 001122334466", mac); end
        n_cmp++; if (ip !== 32'hC0A80003) begin n_err++; $display("FAIL req_ip: got %h want c0a80003", ip); end
        m_mac = 48'h001122334466; m_ip = 32'hC0A80003; m_typ = 1'b0;
    endtask

    task automatic test_reply();
        int ec;
        set_base(); f_op = 16'd2; f_dst = BOARD_MAC; build_frame(); ev_clear();
        send_frame(-1, 2, ec);
        repeat (3) @(negedge clk);
        n_cmp++; if (ev_cyc.size() != 1) begin n_err++; $display("FAIL rep_count: got %0d want 1", ev_cyc.size()); end
        if (ev_cyc.size() >= 1) begin
            n_cmp++; if (ev_cyc[0] != ec) begin n_err++; $display("FAIL rep_latency: got cyc %0d want %0d", ev_cyc[0], ec); end
        end
        n_cmp++; if (typ !== 1'b1) begin n_err++; $display("FAIL rep_type: got %b want 1", typ); end
        n_cmp++; if ({mac, ip} !== {48'h001122334466, 32'hC0A80003}) begin
            n_err++; $display("FAIL rep_addr: got %h/%h want 001122334466/c0a80003", mac, ip); end
        m_mac = 48'h001122334466; m_ip = 32'hC0A80003; m_typ = 1'b1;
    endtask

    task automatic test_rejects();
        int ec;
        for (int k = 0; k < 3; k++) begin
            set_base(); f_smac = 48'h00AABBCCDDEE; f_sip = 32'hC0A80077;
            case (k)
                0: f_tip = 32'hC0A80009;
                1: f_etype = 16'h0800;
                default: f_dst = 48'h001122334477;
            endcase
            build_frame(); ev_clear();
            send_frame(-1, 2, ec);
            repeat (3) @(negedge clk);
            n_cmp++; if (ev_cyc.size() != 0) begin n_err++; $display("FAIL rej%0d_count: got %0d want 0", k, ev_cyc.size()); end
            n_cmp++; if ({typ, mac, ip} !== {m_typ, m_mac, m_ip}) begin
                n_err++; $display("FAIL rej%0d_hold: got %b/%h/%h want %b/%h/%h", k, typ, mac, ip, m_typ, m_mac, m_ip); end
        end
    endtask

    task automatic test_abort();
        int ea, eb;
        set_base(); f_smac = 48'h0A0B0C0D0E0F; f_sip = 32'hC0A8000A; build_frame(); ev_clear();
        send_frame(8 + 14 + 10, 1, ea);
        set_base(); f_op = 16'd2; f_smac = 48'h0050C2123456; f_sip = 32'hC0A80004; build_frame();
        send_frame(-1, 2, eb);
        repeat (3) @(negedge clk);
        n_cmp++; if (ev_cyc.size() != 1) begin n_err++; $display("FAIL abort_count: got %0d want 1", ev_cyc.size()); end
        if (ev_cyc.size() >= 1) begin
            n_cmp++; if (ev_cyc[0] != eb) begin n_err++; $display("FAIL abort_latency: got cyc %0d want %0d", ev_cyc[0], eb); end
        end
        n_cmp++; if ({typ, mac, ip} !== {1'b1, 48'h0050C2123456, 32'hC0A80004}) begin
            n_err++; $display("FAIL abort_out: got %b/%h/%h want 1/0050c2123456/c0a80004", typ, mac, ip); end
        m_typ = 1'b1; m_mac = 48'h0050C2123456; m_ip = 32'hC0A80004;
    endtask

    task automatic test_reset_mid();
        int ec;
        set_base(); f_smac = 48'hA1A2A3A4A5A6; f_sip = 32'hC0A80011; build_frame(); ev_clear();
        for (int i = 0; i < tx_q.size(); i++) begin
            @(negedge clk); dv = 1'b1; rxd = tx_q[i];
            if (i == 8 + 5) rst = 1'b1;
            if (i == 8 + 7) rst = 1'b0;
            if (i == 8 + 6) begin
                n_cmp++; if ({done, typ, mac, ip} !== 82'h0) begin
                    n_err++; $display("FAIL rstmid_clear: got %b/%b/%h/%h want all 0", done, typ, mac, ip); end
            end
        end
        @(negedge clk); dv = 1'b0; rxd = 8'h00;
        repeat (3) @(negedge clk);
        m_typ = 1'b0; m_mac = '0; m_ip = '0;
        n_cmp++; if (ev_cyc.size() != 0) begin n_err++; $display("FAIL rstmid_count: got %0d want 0", ev_cyc.size()); end
        n_cmp++; if ({typ, mac, ip} !== 81'h0) begin n_err++; $display("FAIL rstmid_hold: got %b/%h/%h want 0", typ, mac, ip); end
        set_base(); f_smac = 48'hB1B2B3B4B5B6; f_sip = 32'hC0A80012; build_frame(); ev_clear();
        send_frame(-1, 2, ec);
        repeat (3) @(negedge clk);
        n_cmp++; if (ev_cyc.size() != 1) begin n_err++; $display("FAIL rstmid_next: got %0d want 1", ev_cyc.size()); end
        n_cmp++; if ({mac, ip} !== {48'hB1B2B3B4B5B6, 32'hC0A80012}) begin
            n_err++; $display("FAIL rstmid_addr: got %h/%h want b1b2b3b4b5b6/c0a80012", mac, ip); end
        m_mac = 48'hB1B2B3B4B5B6; m_ip = 32'hC0A80012; m_typ = 1'b0;
    endtask

    task automatic test_back_to_back();
        int ea, eb;
        set_base(); f_smac = 48'h111111111111; f_sip = 32'hC0A80021; build_frame(); ev_clear();
        send_frame(-1, 1, ea);
        set_base(); f_op = 16'd2; f_dst = BOARD_MAC; f_smac = 48'h222222222222; f_sip = 32'hC0A80022;
        build_frame();
        send_frame(-1, 2, eb);
        repeat (3) @(negedge clk);
        n_cmp++; if (ev_cyc.size() != 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", ev_cyc.size()); end
        if (ev_cyc.size() == 2) begin
            n_cmp++; if (ev_cyc[0] != ea || ev_cyc[1] != eb) begin
                n_err++; $display("FAIL b2b_latency: got %0d,%0d want %0d,%0d", ev_cyc[0], ev_cyc[1], ea, eb); end
            n_cmp++; if ({ev_typ[0], ev_mac[0], ev_ip[0]} !== {1'b0, 48'h111111111111, 32'hC0A80021}) begin
                n_err++; $display("FAIL b2b_first: got %b/%h/%h want 0/111111111111/c0a80021", ev_typ[0], ev_mac[0], ev_ip[0]); end
        end
        n_cmp++; if ({typ, mac, ip} !== {1'b1, 48'h222222222222, 32'hC0A80022}) begin
            n_err++; $display("FAIL b2b_second: got %b/%h/%h want 1/222222222222/c0a80022", typ, mac, ip); end
        m_typ = 1'b1; m_mac = 48'h222222222222; m_ip = 32'hC0A80022;
    endtask

    task automatic test_fcs();
        int  ec;
        bit  acc;
        for (int k = 0; k < 2; k++) begin
            set_base(); f_smac = 48'h0C0C0C0C0C00 + 48'(k); f_sip = 32'hC0A80030 + 32'(k);
            f_fcs_flip = (k == 0);
            build_frame(); ev_clear();
            acc = model_accept();
            send_frame(-1, 2, ec);
            repeat (3) @(negedge clk);
            n_cmp++; if (ev_cyc.size() != (acc ? 1 : 0)) begin
                n_err++; $display("FAIL fcs%0d_count: got %0d want %0d", k, ev_cyc.size(), acc); end
            if (acc && ev_cyc.size() == 1) begin
                n_cmp++; if (ev_cyc[0] != ec) begin n_err++; $display("FAIL fcs%0d_latency: got %0d want %0d", k, ev_cyc[0], ec); end
            end
            if (acc) begin m_mac = f_smac; m_ip = f_sip; m_typ = 1'b0; end
            n_cmp++; if ({typ, mac, ip} !== {m_typ, m_mac, m_ip}) begin
                n_err++; $display("FAIL fcs%0d_out: got %b/%h/%h want %b/%h/%h", k, typ, mac, ip, m_typ, m_mac, m_ip); end
        end
    endtask

    task automatic test_random();
        int  ec, kind, ifg;
        bit  acc;
        for (int n = 0; n < 24; n++) begin
            set_base();
            f_dst  = $urandom_range(0, 1) ? BOARD_MAC : 48'hFFFF_FFFF_FFFF;
            f_seth = {16'($urandom), $urandom};
            f_smac = {16'($urandom), $urandom};
            f_sip  = $urandom;
            f_tmac = {16'($urandom), $urandom};
            f_op   = 16'($urandom_range(1, 2));
            f_pad  = $urandom_range(0, 24);
            kind   = $urandom_range(0, 8);
            case (kind)
                3: f_dst = {16'($urandom), $urandom};
                4: f_etype = 16'h0806 ^ (16'h1 << $urandom_range(0, 15));
                5: f_op = 16'($urandom_range(0, 3)) << (8 * $urandom_range(0, 1));
                6: f_tip = BOARD_IP ^ (32'h1 << $urandom_range(0, 31));
                7: begin
                    f_pre_bad  = 1'b1;
                    f_pre_idx  = $urandom_range(1, 7);
                    f_pre_byte = ((f_pre_idx == 7) ? 8'hD5 : 8'h55) ^ (8'h01 << $urandom_range(0, 7));
                end
                8: f_fcs_flip = 1'b1;
                default: ;
            endcase
            acc = model_accept();
            ifg = $urandom_range(1, 3);
            build_frame(); ev_clear();
            send_frame(-1, ifg, ec);
            repeat (3) @(negedge clk);
            n_cmp++; if (ev_cyc.size() != (acc ? 1 : 0)) begin
                n_err++; $display("FAIL rnd%0d_count: kind %0d got %0d want %0d", n, kind, ev_cyc.size(), acc); end
            if (acc && ev_cyc.size() == 1) begin
                n_cmp++; if (ev_cyc[0] != ec) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, ev_cyc[0], ec); end
            end
            if (acc) begin m_mac = f_smac; m_ip = f_sip; m_typ = (f_op == 16'd2); end
            n_cmp++; if ({typ, mac, ip} !== {m_typ, m_mac, m_ip}) begin
                n_err++; $display("FAIL rnd%0d_out: kind %0d got %b/%h/%h want %b/%h/%h", n, kind, typ, mac, ip, m_typ, m_mac, m_ip); end
        end
    endtask

    task automatic test_integrity();
        n_cmp++; if (width_err != 0) begin n_err++; $display("FAIL done_width: got %0d multi-cycle pulses want 0", width_err); end
        n_cmp++; if (hold_err != 0) begin n_err++; $display("FAIL out_hold: got %0d changes outside done want 0", hold_err); end
    endtask

    initial begin
        test_reset();
        test_request();
        test_reply();
        test_rejects();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_fcs();
        test_random();
        test_integrity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arp_rx.md
Name: arp_rx

Overview:
- GMII receive-side ARP frame parser. Consumes the raw byte stream from the PHY receive path, validates preamble, Ethernet header and ARP payload, and reports sender MAC/IP and opcode of ARP frames addressed to this board.
- Sits beside the ARP transmitter inside the ARP subsystem. Its outputs feed the controller that decides whether to answer requests and which peer addresses to use for transmission.

Parameters:
- BOARD_MAC, 48'h00_11_22_33_44_55, local MAC; destination MAC must equal this or broadcast 48'hff_ff_ff_ff_ff_ff.
- BOARD_IP, {8'd192,8'd168,8'd0,8'd2}, local IP; ARP target IP must equal this.

Ports:
- gmii_rx_clk  in  1  GMII receive clock, 125 MHz.
- rst  in  1  reset, asynchronous, active-high.
- gmii_rx_dv  in  1  receive data valid.
- gmii_rxd  in  8  receive data byte.
- arp_rx_done  out  1  one-cycle pulse: valid ARP frame accepted.
- arp_rx_type  out  1  0 = request (opcode 1), 1 = reply (opcode 2); valid from done onward.
- src_mac  out  48  sender hardware address of last accepted frame.
- src_ip  out  32  sender protocol address of last accepted frame.

Behaviour:
- Clock and reset are decided: one clock, gmii_rx_clk; reset rst is asynchronous and active-high. On rst all outputs are 0, state is IDLE and all counters and shift registers are 0.
- Byte counter: 5 bits, cleared on every state change.
- FSM, advancing one byte per cycle while gmii_rx_dv=1:
  - IDLE: byte 0x55 with dv=1 -> PREAMBLE, cnt=1.
  - PREAMBLE: needs 0x55 at cnt 1..6, then 0xD5 -> ETH_HEAD. Any other byte -> RX_END.
  - ETH_HEAD: 14 bytes.
    - Bytes 0-5 form the destination MAC; it must equal BOARD_MAC or all-ones, else RX_END.
    - Bytes 6-11 are ignored.
    - Bytes 12-13 must be 0x08,0x06, else RX_END.
  - ARP_DATA: 28 bytes.
    - Bytes 6-7: opcode, must be 0x0001 or 0x0002, else RX_END.
    - Bytes 8-13: sender MAC, shifted in MSB first.
    - Bytes 14-17: sender IP.
    - Bytes 24-27: target IP, compared against BOARD_IP after byte 27.
    - Bytes 0-5 and 18-23 are not checked.
    - After byte 27: on a match, latch the shift registers into src_mac, src_ip and arp_rx_type, pulse arp_rx_done for the following cycle, and go to RX_END. On a mismatch, go to RX_END with no pulse and no output change.
  - RX_END: discard bytes (padding, FCS, error frames) until dv=0 -> IDLE.
- dv falling in PREAMBLE, ETH_HEAD or ARP_DATA: abort -> IDLE, no done, outputs unchanged.
- Done latency: done is high exactly 1 cycle after the cycle sampling target-IP byte 27; its width is exactly 1 cycle.
- src_mac, src_ip and arp_rx_type change only in the done cycle and hold their value otherwise.
- A new frame is accepted only after dv has been low for at least 1 cycle (back-to-back frames need IFG ≥1).
- Reset asserted mid-frame: immediate clear, no done; the frame in progress is lost even after rst releases, until dv is low again.

Optional Feature:
- Macro ARP_RX_CRC_CHK_EN.
- Defined:
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over the destination MAC through the end of FCS.
  - At byte 27, pass/fail is stored instead of pulsing done.
  - In RX_END, on the dv falling edge, done pulses 1 cycle after dv=0 only if the stored result passed and the CRC residue equals 0xC704DD7B. Outputs latch at that same cycle.
  - A bad CRC drops the frame silently.
- Undefined: no CRC logic; timing is as described under Behaviour.

Test Plan:
- Frame: broadcast destination, type 0x0806, opcode 1, sender 00_11_22_33_44_66 / 192.168.0.3, target IP 192.168.0.2 -> done one pulse 1 cycle after target byte 27; type=0; src_mac=48'h001122334466; src_ip=32'hC0A80003.
- Same frame with opcode 2 and destination MAC 00_11_22_33_44_55 -> done, type=1, same addresses.
- Target IP 192.168.0.9, ethertype 0x0800, or destination MAC 00_11_22_33_44_77 -> no done; outputs keep previous values.
- dv dropped at ARP byte 10, then a valid frame 1 cycle later -> first frame gives no done; second frame gives done with its own addresses.
- rst asserted at ETH_HEAD byte 5 for 2 cycles -> all outputs 0; the rest of that frame is ignored; the next valid frame is accepted.
- With ARP_RX_CRC_CHK_EN: valid frame with correct FCS -> done 1 cycle after dv falls. Same frame with one FCS bit flipped -> no done.
